// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared types and constants for the bit-serial subtractor.
//   - sub_state_t   : control FSM state encoding (IDLE, RUN, DONE)
//   - SUB_WIDTH_DEF : default operand width
//   - sub_cnt_width : width of the bit-step counter for a given operand width
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    localparam int SUB_WIDTH_DEF = 8;

    // $clog2(2) is 1, so the floor of 1 only protects against degenerate widths.
    function automatic int sub_cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fullsub_cell.sv
// -----------------------------------------------------------------------------
// fullsub_cell
//   One-bit full subtractor computing x - y - bin.
//   Ports:
//     d   (out) difference bit
//     bo  (out) borrow out
//     x   (in)  minuend bit
//     y   (in)  subtrahend bit
//     bin (in)  borrow in
// -----------------------------------------------------------------------------
module fullsub_cell (
    output logic d,
    output logic bo,
    input  logic x,
    input  logic y,
    input  logic bin
);

    assign d  = x ^ y ^ bin;
    // Borrow when y exceeds x, or when x == y and a borrow is already pending.
    assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial a - b, LSB first, one bit per clock through a single
//   fullsub_cell and a registered borrow.
//
//   Handshake: start is accepted on any edge where busy = 0 (IDLE or DONE).
//   busy is high for the WIDTH bit steps; done pulses for one cycle after the
//   last step, at which point diff/bout/ovf carry the new result. start while
//   busy = 1 is ignored.
//
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     start         launch request
//     bin           initial borrow (only with SERIAL_SUBTRACTOR_BIN_EN)
//     a, b          minuend / subtrahend, captured on the accepting edge
//     busy, done    status
//     diff          a - b (- bin) modulo 2^WIDTH
//     bout          final borrow
//     ovf           two's-complement overflow
//     state_dbg     current FSM state, for observation only
//
//   Configuration macro: SERIAL_SUBTRACTOR_BIN_EN adds the bin input so words
//   can be chained through bout -> bin; without it the initial borrow is 0.
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_SUBTRACTOR_BIN_EN
    input  logic             bin,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output sub_state_t       state_dbg
);

    localparam int CW = sub_cnt_width(WIDTH);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             last_step;
    logic             bin_init;
    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] res_shift;

`ifdef SERIAL_SUBTRACTOR_BIN_EN
    assign bin_init = bin;
`else
    assign bin_init = 1'b0;
`endif

    assign accept    = start && (state_q != RUN);
    assign last_step = (cnt_q == CW'(WIDTH - 1));

    fullsub_cell u_cell (
        .d   (cell_d),
        .bo  (cell_bo),
        .x   (sa_q[0]),
        .y   (sb_q[0]),
        .bin (borrow_q)
    );

    // New bits enter at the MSB so after WIDTH steps bit 0 sits at the LSB.
    assign res_shift = {cell_d, res_q[WIDTH-1:1]};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        state_dbg = state_q;
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        if (accept) begin
            sa_d     = a;
            sb_d     = b;
            res_d    = '0;
            borrow_d = bin_init;
            cnt_d    = '0;
            a_msb_d  = a[WIDTH-1];
            b_msb_d  = b[WIDTH-1];
        end else if (state_q == RUN) begin
            sa_d     = sa_q >> 1;
            sb_d     = sb_q >> 1;
            res_d    = res_shift;
            borrow_d = cell_bo;
            if (last_step) begin
                diff_d = res_shift;
                bout_d = cell_bo;
                // Overflow only possible when operand signs differ; then the
                // result sign must match the minuend sign.
                ovf_d  = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
            end else begin
                cnt_d  = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed bench for serial_subtractor (WIDTH = 8). Each launched operation
//   pushes {ovf, bout, diff} computed by a 9-bit reference subtraction onto
//   exp_q; a monitor pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int W = 8;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  sub_state_t   state_dbg;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef SERIAL_SUBTRACTOR_BIN_EN
    .bin       (bin),
`endif
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .state_dbg (state_dbg)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  logic [W+1:0] exp_q[$];

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic bi);
    logic [W:0]   t;
    logic [W-1:0] d;
    logic         o;
    t = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    d = t[W-1:0];
    o = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
    return {o, t[W], d};
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("diff", 32'(diff), 32'(e[W-1:0]));
        check("bout", 32'(bout), 32'(e[W]));
        check("ovf",  32'(ovf),  32'(e[W+1]));
        check("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  // Pulse start for one cycle; queue the expectation only if it will be accepted.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                        input bit expect_accept);
    @(negedge clk);
    a = x; b = y; bin = bi; start = 1'b1;
`ifdef SERIAL_SUBTRACTOR_BIN_EN
    if (expect_accept) exp_q.push_back(model(x, y, bi));
`else
    if (expect_accept) exp_q.push_back(model(x, y, 1'b0));
`endif
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) until done is seen at a negedge; returns busy cycles observed.
  task automatic wait_done(output int busy_cycles);
    int guard;
    busy_cycles = 0;
    guard = 0;
    while (done !== 1'b1 && guard < 100) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("done_timeout", 32'(done), 32'd1);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int bc;
    int t_first;
    int seen_done;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // 5 - 3, busy for exactly W cycles
    launch(8'h05, 8'h03, 1'b0, 1'b1);
    wait_done(bc);
    check("busy_cycles", 32'(bc), 32'(W + 1 - 1));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);

    // 3 - 5; previous result must hold during RUN
    launch(8'h03, 8'h05, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("hold_diff", 32'(diff), 32'h02);
    check("hold_busy", 32'(busy), 32'd1);
    wait_done(bc);
    @(negedge clk);

    launch(8'h80, 8'h01, 1'b0, 1'b1);
    wait_done(bc);
    @(negedge clk);
    launch(8'h7F, 8'hFF, 1'b0, 1'b1);
    wait_done(bc);
    @(negedge clk);

    // Ignored mid-RUN start, then back-to-back start in the DONE cycle
    launch(8'h10, 8'h01, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc);
    t_first = cyc;
    a = 8'h20; b = 8'h01; start = 1'b1;
    exp_q.push_back(model(8'h20, 8'h01, 1'b0));
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_drop", 32'(done), 32'd0);
    check("b2b_busy_rise", 32'(busy), 32'd1);
    wait_done(bc);
    check("b2b_spacing", 32'(cyc - t_first), 32'd9);
    @(negedge clk);

    // Reset in the middle of a run
    launch(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_diff", 32'(diff), 32'd0);
    check("arst_bout", 32'(bout), 32'd0);
    check("arst_ovf",  32'(ovf),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    check("no_done_after_reset", 32'(seen_done), 32'd0);
    check("idle_after_reset", 32'(state_dbg), 32'(IDLE));
    launch(8'h09, 8'h09, 1'b0, 1'b1);
    wait_done(bc);
    @(negedge clk);

`ifdef SERIAL_SUBTRACTOR_BIN_EN
    launch(8'h05, 8'h03, 1'b1, 1'b1);
    wait_done(bc);
    @(negedge clk);
    launch(8'h00, 8'h00, 1'b1, 1'b1);
    wait_done(bc);
    @(negedge clk);
`endif

    // A few random operands
    for (int i = 0; i < 8; i++) begin
      launch(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'b1);
      wait_done(bc);
      @(negedge clk);
    end

    repeat (2) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned/two's-complement subtractor computing `a - b` LSB-first, one bit per clock. Each bit uses a single full-subtractor cell plus a registered borrow. It is the inverse-operation companion to the gate-level full adder and serves as the area-minimal arithmetic datapath for multi-cycle units. A start/busy/done handshake lets a controller launch one operation and collect the difference, final borrow and signed overflow.

## Interface
- `WIDTH`, default 8: operand and result width in bits, valid range 2..32.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request pulse; sampled only when `busy`=0.
- `a`  input  WIDTH  minuend; captured on the accepting edge.
- `b`  input  WIDTH  subtrahend; captured on the accepting edge.
- `busy`  output  1  high while bits are being processed.
- `done`  output  1  one-cycle pulse; the result is valid.
- `diff`  output  WIDTH  `a - b` modulo 2^WIDTH.
- `bout`  output  1  final borrow; for unsigned operands, 1 iff `a < b`.
- `ovf`  output  1  two's-complement overflow of the subtraction.

## Operation
- FSM states are IDLE, RUN and DONE.
  - Reset forces IDLE.
  - IDLE -> RUN when `start`=1.
  - RUN -> DONE after WIDTH bit steps.
  - DONE -> RUN if `start`=1; otherwise DONE -> IDLE.
- Accepting edge:
  - Load shift registers `sa`=`a` and `sb`=`b`.
  - Clear the borrow register and set the bit counter to 0.
- Each RUN edge:
  - Feed `sa[0]`, `sb[0]` and the borrow into the cell.
  - Cell outputs are `d = x ^ y ^ bin` and `bo = (~x & y) | (~(x ^ y) & bin)`.
  - Shift `d` into the result register from the MSB end, shift `sa` and `sb` right, register `bo` as the new borrow, and increment the counter.
- On the last RUN edge (counter = WIDTH-1):
  - Copy the completed result to `diff`.
  - Copy the final `bo` to `bout`.
  - Set `ovf = (a_msb != b_msb) & (diff_msb != a_msb)`, using MSBs latched at accept.
- `diff`, `bout` and `ovf` hold the previous result throughout RUN. They change only on the last RUN edge and hold until the next completion.
- `start` while `busy`=1 is ignored: no restart and no operand recapture.
- Counter width is `$clog2(WIDTH)`, with no wrap beyond WIDTH-1.

## Timing
- Reset values: `busy`=0, `done`=0, `diff`=0, `bout`=0, `ovf`=0. State is IDLE and all internal registers are 0.
- Accept at edge E0: `busy` is 1 from after E0 through the cycle ending at edge E(WIDTH).
- After edge E(WIDTH):
  - `done` is 1 for exactly one cycle, from E(WIDTH) to E(WIDTH+1).
  - `busy` is 0 in that cycle.
  - Results are valid from that cycle onward.
- Latency from accept to `done` is WIDTH cycles. Back-to-back throughput is one operation per WIDTH+1 cycles.
- `start`=1 during the DONE cycle is accepted at E(WIDTH+1). `busy` rises the next cycle and `done` drops.
- If `rst_n` is asserted mid-RUN, all outputs return immediately (asynchronously) to their reset values and the operation is discarded. After release, the block waits in IDLE for a new `start`.
- `a` and `b` may change freely after the accepting edge.

## Configuration
- Macro `SERIAL_SUBTRACTOR_BIN_EN`.
- Defined:
  - Adds input port `bin` (1 bit), sampled on the accepting edge as the initial borrow.
  - Result becomes `a - b - bin`, which allows multi-word chaining through `bout` -> `bin`.
  - `ovf` uses the same MSB rule.
- Undefined: no `bin` port, and the initial borrow is constant 0.

## Structure
- Package `serial_subtractor_pkg`:
  - State enum `sub_state_t` (IDLE, RUN, DONE).
  - `SUB_WIDTH_DEF` = 8.
  - Counter-width function.
- Sub-module `fullsub_cell`:
  - Purely combinational.
  - Ports `(d, bo, x, y, bin)`.
  - Instantiated once.
- Top level holds the FSM, shift registers, borrow flop, counter and output registers.

## Test plan
- WIDTH=8, a=0x05, b=0x03, start at E0 -> `done` after E8: `diff`=0x02, `bout`=0, `ovf`=0, with `busy` high for exactly 8 cycles.
- a=0x03, b=0x05 -> `diff`=0xFE, `bout`=1, `ovf`=0.
- a=0x80, b=0x01 -> `diff`=0x7F, `bout`=0, `ovf`=1. Then a=0x7F, b=0xFF -> `diff`=0x80, `bout`=1, `ovf`=1.
- Start with a=0x10, b=0x01, pulse `start` with a=0xFF mid-RUN, then start a=0x20, b=0x01 in the DONE cycle:
  - First result is `diff`=0x0F (the mid-RUN start is ignored).
  - Second result is `diff`=0x1F, with `done` exactly 9 cycles after the first `done`.
- Assert `rst_n`=0 at bit 4 of a=0xAA, b=0x55 -> all outputs 0 immediately, no `done` appears, and a new op a=0x09, b=0x09 gives `diff`=0x00, `bout`=0.
- With `SERIAL_SUBTRACTOR_BIN_EN`: a=0x05, b=0x03, `bin`=1 -> `diff`=0x01. a=0x00, b=0x00, `bin`=1 -> `diff`=0xFF, `bout`=1.
